// File: rtl/control_fsm_cpu.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm_cpu
// Description : Multi-cycle control unit for data_path_cpu. Decodes
//               opcode/funct, sequences one instruction at a time through
//               DECODE/EXEC/MEM/WB/BR/JMP, stalls in DECODE on register
//               hazards, halts on illegal opcodes or on a stall timeout, and
//               counts retired instructions.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               opcode, funct        - instruction fields from the datapath
//               is_alu_zero          - ALU zero flag (sampled at end of EXEC)
//               is_full_rnum1/2      - rs/rt pending-write hazard flags
//               is_load_PC, is_write_reg, is_write_mem - single-cycle enables
//               opcode_alu, is_R/I/J_type, is_write_from_mem,
//               control_mux_for_PC   - datapath steering (Moore)
//               halted, stall_timeout, retired_count - status
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm_cpu #(
    parameter int STALL_LIMIT = 255,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                is_alu_zero,
    input  logic                is_full_rnum1,
    input  logic                is_full_rnum2,
    output logic                is_load_PC,
    output logic                is_write_reg,
    output logic                is_write_mem,
    output logic [5:0]          opcode_alu,
    output logic                is_R_type,
    output logic                is_I_type,
    output logic                is_J_type,
    output logic                is_write_from_mem,
    output logic [1:0]          control_mux_for_PC,
    output logic                halted,
    output logic                stall_timeout,
    output logic [RETIRE_W-1:0] retired_count
);

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    localparam logic [2:0] S_DECODE = 3'd0;
    localparam logic [2:0] S_EXEC   = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_BR     = 3'd4;
    localparam logic [2:0] S_JMP    = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [2:0] C_R    = 3'd0;
    localparam logic [2:0] C_ADDI = 3'd1;
    localparam logic [2:0] C_LW   = 3'd2;
    localparam logic [2:0] C_SW   = 3'd3;
    localparam logic [2:0] C_BEQ  = 3'd4;
    localparam logic [2:0] C_J    = 3'd5;
    localparam logic [2:0] C_ILL  = 3'd6;

    localparam logic [5:0] c_ALU_ADD = 6'b100000;
    localparam logic [5:0] c_ALU_SUB = 6'b100010;

    logic [2:0]          r_state;
    logic [2:0]          r_class;
    logic [5:0]          r_alu;
    logic                r_zero;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [RETIRE_W-1:0] r_retired;

    logic [2:0]          w_state_nxt;
    logic [2:0]          w_class_nxt;
    logic [5:0]          w_alu_nxt;
    logic                w_zero_nxt;
    logic                w_timeout_nxt;
    logic [CNT_W-1:0]    w_stall_cnt_nxt;
    logic                w_retire;

    logic [2:0]          w_dec_class;
    logic [5:0]          w_dec_alu;
    logic                w_hazard;
    logic                w_in_instr;

    // Instruction decode of the live opcode; only consumed in DECODE.
    always_comb begin
        w_dec_class = C_ILL;
        w_dec_alu   = 6'd0;
        case (opcode)
            6'b000000: begin w_dec_class = C_R;    w_dec_alu = funct;     end
            6'b001000: begin w_dec_class = C_ADDI; w_dec_alu = c_ALU_ADD; end
            6'b100011: begin w_dec_class = C_LW;   w_dec_alu = c_ALU_ADD; end
            6'b101011: begin w_dec_class = C_SW;   w_dec_alu = c_ALU_ADD; end
            6'b000100: begin w_dec_class = C_BEQ;  w_dec_alu = c_ALU_SUB; end
            6'b000010: begin w_dec_class = C_J;    w_dec_alu = 6'd0;      end
            default:   begin w_dec_class = C_ILL;  w_dec_alu = 6'd0;      end
        endcase
    end

    // rt only matters for instructions that actually read it; J reads nothing.
    assign w_hazard = (w_dec_class != C_J) &&
                      (is_full_rnum1 ||
                       (is_full_rnum2 && ((w_dec_class == C_R) ||
                                          (w_dec_class == C_SW) ||
                                          (w_dec_class == C_BEQ))));

    // Next-state and Moore outputs.
    always_comb begin
        w_state_nxt        = r_state;
        w_class_nxt        = r_class;
        w_alu_nxt          = r_alu;
        w_zero_nxt         = r_zero;
        w_timeout_nxt      = r_timeout;
        w_stall_cnt_nxt    = r_stall_cnt;
        w_retire           = 1'b0;

        is_load_PC         = 1'b0;
        is_write_reg       = 1'b0;
        is_write_mem       = 1'b0;
        opcode_alu         = 6'd0;
        is_R_type          = 1'b0;
        is_I_type          = 1'b0;
        is_J_type          = 1'b0;
        is_write_from_mem  = 1'b0;
        control_mux_for_PC = 2'd0;
        halted             = 1'b0;
        stall_timeout      = r_timeout;

        w_in_instr = (r_state == S_EXEC) || (r_state == S_MEM) ||
                     (r_state == S_WB)   || (r_state == S_BR)  ||
                     (r_state == S_JMP);
        if (w_in_instr) begin
            opcode_alu = r_alu;
            is_R_type  = (r_class == C_R);
            is_I_type  = (r_class == C_ADDI) || (r_class == C_LW) ||
                         (r_class == C_SW);
            is_J_type  = (r_class == C_J);
        end

        case (r_state)
            S_DECODE: begin
                if (w_hazard) begin
                    // The STALL_LIMIT-th consecutive stall cycle is the timeout.
                    if (r_stall_cnt == CNT_W'(STALL_LIMIT - 1)) begin
                        w_state_nxt   = S_HALT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
                    end
                end else begin
                    w_class_nxt     = w_dec_class;
                    w_alu_nxt       = w_dec_alu;
                    w_stall_cnt_nxt = '0;
                    if (w_dec_class == C_J)
                        w_state_nxt = S_JMP;
                    else if (w_dec_class == C_ILL)
                        w_state_nxt = S_HALT;
                    else
                        w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    C_LW, C_SW: w_state_nxt = S_MEM;
                    C_BEQ: begin
                        w_state_nxt = S_BR;
                        w_zero_nxt  = is_alu_zero;
                    end
                    default:    w_state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (r_class == C_SW) begin
                    is_write_mem = 1'b1;
                    is_load_PC   = 1'b1;
                    w_retire     = 1'b1;
                    w_state_nxt  = S_DECODE;
                end else begin
                    is_write_from_mem = 1'b1;
                    w_state_nxt       = S_WB;
                end
            end
            S_WB: begin
                is_write_reg      = 1'b1;
                is_load_PC        = 1'b1;
                is_write_from_mem = (r_class == C_LW);
                w_retire          = 1'b1;
                w_state_nxt       = S_DECODE;
            end
            S_BR: begin
                is_load_PC         = 1'b1;
                control_mux_for_PC = {1'b0, r_zero};
                w_retire           = 1'b1;
                w_state_nxt        = S_DECODE;
            end
            S_JMP: begin
                is_load_PC         = 1'b1;
                control_mux_for_PC = 2'd2;
                w_retire           = 1'b1;
                w_state_nxt        = S_DECODE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_DECODE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_DECODE;
            r_class     <= C_R;
            r_alu       <= 6'd0;
            r_zero      <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_retired   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_class     <= w_class_nxt;
            r_alu       <= w_alu_nxt;
            r_zero      <= w_zero_nxt;
            r_timeout   <= w_timeout_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            if (w_retire)
                r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    assign retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_fsm_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_fsm_cpu
// Description : Directed self-checking bench for control_fsm_cpu. Per-cycle
//               expected output vectors are queued and compared as the DUT
//               steps. A second instance with STALL_LIMIT = 4 shares the
//               inputs for the stall-timeout boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_alu_zero;
    logic        is_full_rnum1;
    logic        is_full_rnum2;

    logic        is_load_PC, is_write_reg, is_write_mem;
    logic [5:0]  opcode_alu;
    logic        is_R_type, is_I_type, is_J_type, is_write_from_mem;
    logic [1:0]  control_mux_for_PC;
    logic        halted, stall_timeout;
    logic [31:0] retired_count;

    logic        d4_load_PC, d4_write_reg, d4_write_mem;
    logic [5:0]  d4_opcode_alu;
    logic        d4_R, d4_I, d4_J, d4_wfm;
    logic [1:0]  d4_mux;
    logic        d4_halted, d4_timeout;
    logic [31:0] d4_retired;

    int n_assert = 0;
    int n_fail   = 0;

    logic [48:0] q_exp[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    control_fsm_cpu #(.STALL_LIMIT(255), .RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .is_alu_zero(is_alu_zero), .is_full_rnum1(is_full_rnum1),
        .is_full_rnum2(is_full_rnum2),
        .is_load_PC(is_load_PC), .is_write_reg(is_write_reg),
        .is_write_mem(is_write_mem), .opcode_alu(opcode_alu),
        .is_R_type(is_R_type), .is_I_type(is_I_type), .is_J_type(is_J_type),
        .is_write_from_mem(is_write_from_mem),
        .control_mux_for_PC(control_mux_for_PC),
        .halted(halted), .stall_timeout(stall_timeout),
        .retired_count(retired_count)
    );

    control_fsm_cpu #(.STALL_LIMIT(4), .RETIRE_W(32)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .is_alu_zero(is_alu_zero), .is_full_rnum1(is_full_rnum1),
        .is_full_rnum2(is_full_rnum2),
        .is_load_PC(d4_load_PC), .is_write_reg(d4_write_reg),
        .is_write_mem(d4_write_mem), .opcode_alu(d4_opcode_alu),
        .is_R_type(d4_R), .is_I_type(d4_I), .is_J_type(d4_J),
        .is_write_from_mem(d4_wfm), .control_mux_for_PC(d4_mux),
        .halted(d4_halted), .stall_timeout(d4_timeout),
        .retired_count(d4_retired)
    );

    // Expected vector layout: lpc,wr,wm,alu[6],R,I,J,wfm,mux[2],halted,timeout,ret[32]
    function automatic logic [48:0] mk(input logic lpc, input logic wr,
                                       input logic wm, input logic [5:0] alu,
                                       input logic r, input logic i,
                                       input logic j, input logic wfm,
                                       input logic [1:0] mux, input logic h,
                                       input logic to, input logic [31:0] ret);
        return {lpc, wr, wm, alu, r, i, j, wfm, mux, h, to, ret};
    endfunction

    task automatic ex(input string tag, input logic [48:0] v);
        q_exp.push_back(v);
        q_tag.push_back(tag);
    endtask

    // Compare the current cycle's outputs against the oldest expectation,
    // then advance one clock (to the next falling edge).
    task automatic cyc();
        logic [48:0] obs;
        logic [48:0] e;
        string       t;
        obs = {is_load_PC, is_write_reg, is_write_mem, opcode_alu, is_R_type,
               is_I_type, is_J_type, is_write_from_mem, control_mux_for_PC,
               halted, stall_timeout, retired_count};
        n_assert++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
        end else begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk4(input string tag, input logic [1:0] exp_v);
        n_assert++;
        assert ({d4_halted, d4_timeout} === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag,
                   {d4_halted, d4_timeout}, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; opcode = 6'd0; funct = 6'd0; is_alu_zero = 1'b0;
        is_full_rnum1 = 1'b0; is_full_rnum2 = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset state
        ex("reset", mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,0)); cyc();
        chk4("reset_dut4", 2'b00);
        rst = 1'b0;

        // R-type ADD
        opcode = 6'b000000; funct = 6'b100000;
        ex("r_dec",  mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,0)); cyc();
        ex("r_exec", mk(0,0,0,6'h20,1,0,0,0,2'd0,0,0,0)); cyc();
        ex("r_wb",   mk(1,1,0,6'h20,1,0,0,0,2'd0,0,0,0)); cyc();

        // LW
        opcode = 6'b100011; funct = 6'b101010;
        ex("lw_dec",  mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,1)); cyc();
        ex("lw_exec", mk(0,0,0,6'h20,0,1,0,0,2'd0,0,0,1)); cyc();
        ex("lw_mem",  mk(0,0,0,6'h20,0,1,0,1,2'd0,0,0,1)); cyc();
        ex("lw_wb",   mk(1,1,0,6'h20,0,1,0,1,2'd0,0,0,1)); cyc();

        // SW
        opcode = 6'b101011;
        ex("sw_dec",  mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,2)); cyc();
        ex("sw_exec", mk(0,0,0,6'h20,0,1,0,0,2'd0,0,0,2)); cyc();
        ex("sw_mem",  mk(1,0,1,6'h20,0,1,0,0,2'd0,0,0,2)); cyc();

        // BEQ taken: zero high at end of EXEC
        opcode = 6'b000100; is_alu_zero = 1'b0;
        ex("beq1_dec",  mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,3)); cyc();
        is_alu_zero = 1'b1;
        ex("beq1_exec", mk(0,0,0,6'h22,0,0,0,0,2'd0,0,0,3)); cyc();
        is_alu_zero = 1'b0;
        ex("beq1_br",   mk(1,0,0,6'h22,0,0,0,0,2'd1,0,0,3)); cyc();

        // BEQ not taken: zero high everywhere except at end of EXEC
        is_alu_zero = 1'b1;
        ex("beq0_dec",  mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,4)); cyc();
        is_alu_zero = 1'b0;
        ex("beq0_exec", mk(0,0,0,6'h22,0,0,0,0,2'd0,0,0,4)); cyc();
        is_alu_zero = 1'b1;
        ex("beq0_br",   mk(1,0,0,6'h22,0,0,0,0,2'd0,0,0,4)); cyc();
        is_alu_zero = 1'b0;

        // J ignores both hazard flags
        opcode = 6'b000010; is_full_rnum1 = 1'b1; is_full_rnum2 = 1'b1;
        ex("j_dec", mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,5)); cyc();
        ex("j_jmp", mk(1,0,0,6'h00,0,0,1,0,2'd2,0,0,5)); cyc();
        is_full_rnum1 = 1'b0; is_full_rnum2 = 1'b0;

        // R-type stalled 5 cycles on rt; dut4 times out after its 4th stall
        opcode = 6'b000000; funct = 6'b100101; is_full_rnum2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ex("stall_dec", mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,6));
            if (k == 3) chk4("dut4_before_limit", 2'b00);
            if (k == 4) chk4("dut4_timeout", 2'b11);
            cyc();
        end
        is_full_rnum2 = 1'b0;
        ex("stall_go",   mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,6)); cyc();
        ex("stall_exec", mk(0,0,0,6'h25,1,0,0,0,2'd0,0,0,6)); cyc();
        ex("stall_wb",   mk(1,1,0,6'h25,1,0,0,0,2'd0,0,0,6)); cyc();
        chk4("dut4_stays_halted", 2'b11);

        // Illegal opcode halts without retiring
        opcode = 6'b111111;
        ex("ill_dec", mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,7)); cyc();
        opcode = 6'b000000;
        ex("ill_halt1", mk(0,0,0,6'h00,0,0,0,0,2'd0,1,0,7)); cyc();
        ex("ill_halt2", mk(0,0,0,6'h00,0,0,0,0,2'd0,1,0,7)); cyc();
        rst = 1'b1;
        ex("ill_halt3", mk(0,0,0,6'h00,0,0,0,0,2'd0,1,0,7)); cyc();
        rst = 1'b0;
        chk4("dut4_after_reset", 2'b00);

        // LW interrupted by reset during MEM
        opcode = 6'b100011;
        ex("lwr_dec",  mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,0)); cyc();
        ex("lwr_exec", mk(0,0,0,6'h20,0,1,0,0,2'd0,0,0,0)); cyc();
        rst = 1'b1;
        ex("lwr_mem",  mk(0,0,0,6'h20,0,1,0,1,2'd0,0,0,0)); cyc();
        rst = 1'b0; is_full_rnum1 = 1'b1;
        ex("lwr_post1", mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,0)); cyc();
        ex("lwr_post2", mk(0,0,0,6'h00,0,0,0,0,2'd0,0,0,0)); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_fsm_cpu.md
Name: control_fsm_cpu

Overview:
- Multi-cycle control unit that sequences data_path_cpu: it decodes opcode/funct and drives every datapath control input, one instruction at a time.
- It stalls in decode on register hazards reported by the datapath's hazard flags, and resolves branches from the ALU zero flag.
- It halts on illegal opcodes or on a hazard stall timeout.
- It also counts retired instructions.

Parameters:
- STALL_LIMIT, 255: maximum consecutive hazard-stall cycles before the block times out and halts.
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction bits [31:26] from the datapath.
- funct  in  6  instruction bits [5:0] from the datapath.
- is_alu_zero  in  1  ALU zero flag.
- is_full_rnum1  in  1  hazard: rs is pending a write.
- is_full_rnum2  in  1  hazard: rt is pending a write.
- is_load_PC  out  1  PC load enable.
- is_write_reg  out  1  register-file write enable.
- is_write_mem  out  1  data-memory write enable.
- opcode_alu  out  6  ALU operation code (funct encoding).
- is_R_type  out  1  instruction class flag.
- is_I_type  out  1  selects IMM for the ALU operand and rt as the write register.
- is_J_type  out  1  instruction class flag.
- is_write_from_mem  out  1  selects memory data for register writeback.
- control_mux_for_PC  out  2  next-PC select: 0 = PC+1, 1 = PC+IMM, 2 = ADDR.
- halted  out  1  FSM is in HALT.
- stall_timeout  out  1  the halt was caused by a stall timeout.
- retired_count  out  RETIRE_W  number of completed instructions; wraps modulo 2^RETIRE_W.

Behaviour:
- Decoded opcodes:
  - R 000000: opcode_alu = funct.
  - ADDI 001000: alu = 100000.
  - LW 100011: alu = 100000.
  - SW 101011: alu = 100000.
  - BEQ 000100: alu = 100010.
  - J 000010.
  - Any other opcode is illegal.
- States: DECODE, EXEC, MEM, WB, BR, JMP, HALT. Outputs are Moore: decoded from the state register plus registers latched on DECODE exit (class, alu code). No output depends combinationally on the inputs.
- Reset (rst=1 at an edge, in any state, including mid-instruction or in HALT):
  - state becomes DECODE; all outputs 0; control_mux_for_PC = 0.
  - retired_count = 0, halted = 0, stall_timeout = 0; stall counter cleared.
- DECODE:
  - Hazard condition: is_full_rnum1, OR is_full_rnum2 for R/SW/BEQ. J ignores both flags; ADDI/LW ignore rnum2.
  - If the hazard condition holds, stay in DECODE and increment the stall counter. When the counter reaches STALL_LIMIT with the hazard still present, go to HALT and set stall_timeout = 1.
  - Otherwise latch the class and alu code, clear the stall counter, and go to JMP for J, HALT for illegal opcodes, or EXEC for all others.
- EXEC:
  - Drive opcode_alu and the class flags.
  - is_I_type = 1 for ADDI/LW/SW only; BEQ compares rs with rt, so is_I_type = 0.
  - Next state: R/ADDI go to WB, LW/SW go to MEM, BEQ goes to BR. For BEQ, is_alu_zero is sampled into zero_q at the end of EXEC.
- MEM:
  - LW: is_write_from_mem = 1, then go to WB.
  - SW: is_write_mem = 1, is_load_PC = 1, mux = 0, then go to DECODE (retires).
- WB: is_write_reg = 1, is_load_PC = 1, mux = 0. is_write_from_mem stays 1 for LW. Go to DECODE (retires).
- BR: is_load_PC = 1, mux = 1 if zero_q else 0. Go to DECODE (retires).
- JMP: is_J_type = 1, is_load_PC = 1, mux = 2. Go to DECODE (retires).
- Signal stability:
  - Class flags and opcode_alu hold constant from EXEC through the final state of each instruction, and return to 0 in DECODE.
  - is_load_PC, is_write_reg and is_write_mem are single-cycle pulses, asserted only in the final state of an instruction.
- Latency, DECODE entry to next DECODE with no stalls: J 2 cycles; R/ADDI/SW/BEQ 3 cycles; LW 4 cycles.
- retired_count increments on the edge that leaves each final state.
- HALT: all enables 0, halted = 1. The block stays in HALT until rst; no retire occurs on entry.
- Simultaneous events: rst has priority over every transition. Hazard flags are ignored outside DECODE.

Test Plan:
- R-type ADD (opcode 000000, funct 100000), no hazard:
  - opcode_alu = 100000 and is_R_type = 1 in EXEC.
  - WB cycle has is_write_reg = 1, is_load_PC = 1, mux = 0.
  - 3 cycles total; retired_count 0 -> 1.
- LW then SW:
  - LW: 4 cycles; is_I_type = 1 from EXEC through WB; is_write_from_mem = 1 in MEM and WB; exactly one is_write_reg pulse.
  - SW: 3 cycles; single is_write_mem pulse, with is_load_PC in the same cycle.
- BEQ:
  - is_alu_zero = 1 at end of EXEC -> BR has mux = 1.
  - Repeat with is_alu_zero = 0 -> mux = 0.
  - is_I_type = 0 throughout.
- J (000010) while is_full_rnum1 = 1:
  - No stall; JMP has mux = 2, is_J_type = 1, is_load_PC = 1.
  - 2 cycles total.
- Hazard stall:
  - Hold is_full_rnum2 = 1 for 5 cycles on an R-type -> 5 extra DECODE cycles, then normal completion.
  - With STALL_LIMIT = 4 and the hazard held -> halted = 1 and stall_timeout = 1 after 4 stall cycles.
- Illegal opcode 111111:
  - -> HALT with halted = 1 and retired_count unchanged.
  - Assert rst for 1 cycle -> DECODE with all outputs 0.
  - Also assert rst during MEM of an LW -> no is_write_reg pulse afterwards.
